// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared definitions for the UART TX frame controller.
//  - enum encodings for the FSM state and every transfer-config field
//  - frame_cfg_t: frame settings captured at the handshake
//  - frame_cfg_ok(): field-range check for oversampling / uart_type / stop_bit
package uart_tx_frame_ctrl_pkg;

    localparam int DEF_CHAR_LENGTH = 8;
    localparam int DEF_DIV_WIDTH   = 16;
    // Bit-period counter width: divisor times an oversampling code of up to 8,
    // with one spare bit so the two-stop-bit length (2P) still fits.
    localparam int BAUD_CNT_WIDTH  = DEF_DIV_WIDTH + 4;

    typedef enum logic [3:0] {
        IDLE_STATE   = 4'd0,
        START_STATE  = 4'd1,
        DATA_STATE   = 4'd2,
        PARITY_STATE = 4'd3,
        STOP_STATE   = 4'd4
    } uart_fsm_state_e;

    typedef enum logic [1:0] {
        STOP_1P5 = 2'd0,
        STOP_1   = 2'd1,
        STOP_2   = 2'd2
    } stop_bit_e;

    typedef enum logic [3:0] {
        UART_5 = 4'd5,
        UART_6 = 4'd6,
        UART_7 = 4'd7,
        UART_8 = 4'd8
    } uart_type_e;

    typedef enum logic [3:0] {
        OS_2 = 4'd2,
        OS_4 = 4'd4,
        OS_6 = 4'd6,
        OS_8 = 4'd8
    } oversampling_e;

    typedef enum logic {
        PARITY_EVEN = 1'b0,
        PARITY_ODD  = 1'b1
    } parity_e;

    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } shift_direction_e;

    typedef struct packed {
        logic [3:0] uart_type;
        stop_bit_e  stop_bit;
        logic       msb_first;
        logic       parity_en;
    } frame_cfg_t;

    function automatic logic frame_cfg_ok(input logic [3:0] os,
                                          input logic [3:0] uart_type,
                                          input logic [1:0] stop_bit);
        return (os inside {OS_2, OS_4, OS_6, OS_8}) &&
               (uart_type >= 4'd5) && (uart_type <= 4'd8) &&
               (stop_bit != 2'd3);
    endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_bit_timer.sv
// uart_bit_timer: down-counter that times one UART bit (or the whole stop phase).
//  clk, reset   clock, synchronous active-high reset
//  load         strobe: reload the counter with load_val (= length - 1)
//  load_val     cycles-minus-one of the next bit/phase
//  bit_end      high while the counter sits at 0 (last cycle of the bit)
module uart_bit_timer
    import uart_tx_frame_ctrl_pkg::*;
#(
    parameter int CNT_W = BAUD_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             bit_end
);

    logic [CNT_W-1:0] cnt_q;

    // Parks at 0 when nothing reloads it, so an idle block always reads bit_end=1.
    always_ff @(posedge clk) begin
        if (reset)               cnt_q <= '0;
        else if (load)           cnt_q <= load_val;
        else if (cnt_q != '0)    cnt_q <= cnt_q - CNT_W'(1);
    end

    assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: sequences one UART TX lane IDLE->START->DATA->PARITY->STOP.
//  clk, reset        clock, synchronous active-high reset
//  cfg_*             frame config, captured only at the handshake
//  tx_data/valid     character handshake; tx_ready high only in IDLE
//  tx_serial         registered serial line, idle high
//  busy, fsm_state   current state (busy = not IDLE)
//  frame_done        pulse in the final stop-bit cycle
//  cfg_err           pulse the cycle after a handshake carrying an invalid config
module uart_tx_frame_ctrl
    import uart_tx_frame_ctrl_pkg::*;
#(
    parameter int CHAR_LENGTH = DEF_CHAR_LENGTH,
    parameter int DIV_WIDTH   = DEF_DIV_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DIV_WIDTH-1:0]   cfg_baud_div,
    input  logic [3:0]             cfg_oversampling,
    input  logic [3:0]             cfg_uart_type,
    input  logic [1:0]             cfg_stop_bit,
    input  logic                   cfg_msb_first,
    input  logic                   cfg_parity_en,
    input  logic                   cfg_parity_odd,
    input  logic [CHAR_LENGTH-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx_serial,
    output logic                   busy,
    output logic [3:0]             fsm_state,
    output logic                   frame_done,
    output logic                   cfg_err
);

    localparam int CNT_W = DIV_WIDTH + 4;

    uart_fsm_state_e        state_q, state_d;
    frame_cfg_t             fcfg_q;
    logic [CNT_W-1:0]       period_q, period_fire, stop_len, load_val;
    logic [CHAR_LENGTH-1:0] data_q, type_mask;
    logic                   parity_q;
    logic [2:0]             idx_q, idx_d, sel;
    logic                   fire, cfg_ok, load, bit_end, last_data, line_d;

    assign tx_ready    = (state_q == IDLE_STATE);
    assign busy        = ~tx_ready;
    assign fsm_state   = state_q;
    assign fire        = tx_valid & tx_ready;
    assign cfg_ok      = (cfg_baud_div != '0) &&
                         frame_cfg_ok(cfg_oversampling, cfg_uart_type, cfg_stop_bit);
    assign period_fire = CNT_W'(cfg_baud_div) * CNT_W'(cfg_oversampling);
    assign frame_done  = (state_q == STOP_STATE) && bit_end;
    assign last_data   = ({1'b0, idx_q} == fcfg_q.uart_type - 4'd1);

    // Bits at or above uart_type never reach the line or the parity.
    always_comb begin
        type_mask = '0;
        for (int i = 0; i < CHAR_LENGTH; i++)
            type_mask[i] = (i < int'(cfg_uart_type));
    end

    always_comb begin
        case (fcfg_q.stop_bit)
            STOP_1:   stop_len = period_q;
            STOP_1P5: stop_len = period_q + (period_q >> 1);
            default:  stop_len = period_q << 1;
        endcase
    end

    uart_bit_timer #(.CNT_W(CNT_W)) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .bit_end  (bit_end)
    );

    // Every bit boundary reloads the timer with the length of the bit being entered.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            IDLE_STATE: if (fire && cfg_ok) begin
                state_d  = START_STATE;
                load     = 1'b1;
                load_val = period_fire - CNT_W'(1);
            end
            START_STATE: if (bit_end) begin
                state_d  = DATA_STATE;
                idx_d    = '0;
                load     = 1'b1;
                load_val = period_q - CNT_W'(1);
            end
            DATA_STATE: if (bit_end) begin
                load = 1'b1;
                if (!last_data) begin
                    idx_d    = idx_q + 3'd1;
                    load_val = period_q - CNT_W'(1);
                end else if (fcfg_q.parity_en) begin
                    state_d  = PARITY_STATE;
                    load_val = period_q - CNT_W'(1);
                end else begin
                    state_d  = STOP_STATE;
                    load_val = stop_len - CNT_W'(1);
                end
            end
            PARITY_STATE: if (bit_end) begin
                state_d  = STOP_STATE;
                load     = 1'b1;
                load_val = stop_len - CNT_W'(1);
            end
            STOP_STATE: if (bit_end) state_d = IDLE_STATE;
            default: state_d = IDLE_STATE;
        endcase
    end

    // The line value is chosen from the *next* state so tx_serial can be a flop
    // that changes on the same edge as fsm_state.
    always_comb begin
        sel    = fcfg_q.msb_first ? (fcfg_q.uart_type[2:0] - 3'd1 - idx_d) : idx_d;
        line_d = 1'b1;
        case (state_d)
            START_STATE:  line_d = 1'b0;
            DATA_STATE:   line_d = data_q[sel];
            PARITY_STATE: line_d = parity_q;
            default:      line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE_STATE;
            idx_q     <= '0;
            tx_serial <= 1'b1;
            cfg_err   <= 1'b0;
            fcfg_q    <= '0;
            period_q  <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tx_serial <= line_d;
            cfg_err   <= fire & ~cfg_ok;
            if (fire && cfg_ok) begin
                fcfg_q.uart_type <= cfg_uart_type;
                fcfg_q.stop_bit  <= stop_bit_e'(cfg_stop_bit);
                fcfg_q.msb_first <= cfg_msb_first;
                fcfg_q.parity_en <= cfg_parity_en;
                period_q         <= period_fire;
                data_q           <= tx_data & type_mask;
                parity_q         <= (^(tx_data & type_mask)) ^ cfg_parity_odd;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: a frame-level model expands each accepted character
// into its per-cycle line/state sequence; a compare process checks every cycle.
module tb_uart_tx_frame_ctrl;
    import uart_tx_frame_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cfg_baud_div;
    logic [3:0]  cfg_oversampling, cfg_uart_type;
    logic [1:0]  cfg_stop_bit;
    logic        cfg_msb_first, cfg_parity_en, cfg_parity_odd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready, tx_serial, busy, frame_done, cfg_err;
    logic [3:0]  fsm_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(.CHAR_LENGTH(8), .DIV_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .cfg_baud_div(cfg_baud_div), .cfg_oversampling(cfg_oversampling),
        .cfg_uart_type(cfg_uart_type), .cfg_stop_bit(cfg_stop_bit),
        .cfg_msb_first(cfg_msb_first), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_serial(tx_serial), .busy(busy),
        .fsm_state(fsm_state), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    typedef struct packed {
        logic [15:0] div; logic [3:0] os; logic [3:0] typ; logic [1:0] stop;
        logic msb; logic pen; logic podd;
    } tcfg_t;

    typedef struct packed { logic [3:0] st; logic line; logic done; } rec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic tcfg_t mk(input int div, input int os, input int typ, input int stop,
                                 input bit msb, input bit pen, input bit podd);
        tcfg_t c;
        c.div = 16'(div); c.os = 4'(os); c.typ = 4'(typ); c.stop = 2'(stop);
        c.msb = msb; c.pen = pen; c.podd = podd;
        return c;
    endfunction

    function automatic tcfg_t rand_cfg(input bit allow_bad);
        tcfg_t c;
        c = mk($urandom_range(1, 2), 2 * $urandom_range(1, 4), $urandom_range(5, 8),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
        if (allow_bad && $urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
                0: c.div  = 16'd0;
                1: c.os   = 4'(2 * $urandom_range(0, 7) + 1);
                2: c.typ  = 4'($urandom_range(0, 4));
                default: c.stop = 2'd3;
            endcase
        end
        return c;
    endfunction

    task automatic drive(input tcfg_t c);
        cfg_baud_div = c.div; cfg_oversampling = c.os; cfg_uart_type = c.typ;
        cfg_stop_bit = c.stop; cfg_msb_first = c.msb; cfg_parity_en = c.pen;
        cfg_parity_odd = c.podd;
    endtask

    // ---------------- behavioural model ----------------
    rec_t exp_q[$];
    bit   m_idle = 1'b1;
    bit   err_pend = 1'b0;
    int   last_len = 0;

    task automatic push_bit(input logic [3:0] st, input logic v, input int n);
        rec_t r;
        r.st = st; r.line = v; r.done = 1'b0;
        for (int k = 0; k < n; k++) exp_q.push_back(r);
    endtask

    task automatic push_frame(input tcfg_t c, input logic [7:0] d);
        int p, ty, slen, n0;
        logic par;
        p  = int'(c.div) * int'(c.os);
        ty = int'(c.typ);
        n0 = exp_q.size();
        push_bit(START_STATE, 1'b0, p);
        for (int i = 0; i < ty; i++) push_bit(DATA_STATE, c.msb ? d[ty-1-i] : d[i], p);
        if (c.pen) begin
            par = c.podd;
            for (int i = 0; i < ty; i++) par ^= d[i];
            push_bit(PARITY_STATE, par, p);
        end
        slen = (c.stop == 2'd1) ? p : (c.stop == 2'd0) ? p + p / 2 : 2 * p;
        push_bit(STOP_STATE, 1'b1, slen);
        exp_q[exp_q.size()-1].done = 1'b1;
        last_len = exp_q.size() - n0;
    endtask

    function automatic bit model_cfg_ok();
        return cfg_baud_div != 0 && (cfg_oversampling == 2 || cfg_oversampling == 4 ||
               cfg_oversampling == 6 || cfg_oversampling == 8) &&
               cfg_uart_type >= 5 && cfg_uart_type <= 8 && cfg_stop_bit != 3;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            err_pend = 1'b0;
        end else begin
            err_pend = 1'b0;
            if (tx_valid && m_idle) begin
                if (model_cfg_ok())
                    push_frame(mk(cfg_baud_div, cfg_oversampling, cfg_uart_type, cfg_stop_bit,
                                  cfg_msb_first, cfg_parity_en, cfg_parity_odd), tx_data);
                else
                    err_pend = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        rec_t e;
        bit   exp_err;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_err = err_pend;
            if (exp_q.size() == 0) begin
                m_idle = 1'b1; e.st = IDLE_STATE; e.line = 1'b1; e.done = 1'b0;
            end else begin
                m_idle = 1'b0; e = exp_q.pop_front();
            end
            chk("tx_serial",  tx_serial,  e.line);
            chk("fsm_state",  fsm_state,  e.st);
            chk("busy",       busy,       !m_idle);
            chk("tx_ready",   tx_ready,   m_idle);
            chk("frame_done", frame_done, e.done);
            chk("cfg_err",    cfg_err,    exp_err);
        end
    end

    // ---------------- directed capture helpers ----------------
    logic cap [0:63];
    logic dn  [0:63];

    task automatic send(input logic [7:0] d);
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            cap[k] = tx_serial; dn[k] = frame_done;
            @(negedge clk);
        end
    endtask

    function automatic int line_bad(input logic [31:0] pat, input int cycles, input int p);
        int bad = 0;
        for (int k = 0; k < cycles; k++) if (cap[k] !== pat[k/p]) bad++;
        return bad;
    endfunction

    function automatic int done_pos(input int cycles);
        int pos = -1;
        int n = 0;
        for (int k = 0; k < cycles; k++) if (dn[k] === 1'b1) begin pos = k; n++; end
        return (n == 1) ? pos : -2;
    endfunction

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int ones, gap, ndone, nsent, w;
        bit counting;
        logic [7:0] chars [0:2];
        tcfg_t base;

        tx_valid = 1'b0; tx_data = '0;
        drive(mk(1, 2, 8, 1, 0, 0, 0));
        repeat (3) @(negedge clk);
        chk("rst_serial", tx_serial, 1'b1);
        chk("rst_ready",  tx_ready,  1'b1);
        chk("rst_busy",   busy,      1'b0);
        chk("rst_state",  fsm_state, IDLE_STATE);
        chk("rst_done",   frame_done, 1'b0);
        chk("rst_err",    cfg_err,   1'b0);
        reset = 1'b0;

        // 1: P=2, 8-bit LSB, even parity, 1 stop, 0xA5
        drive(mk(1, 2, 8, 1, 0, 1, 0));
        send(8'hA5);
        capture(22);
        chk("t1_line",  line_bad(32'b10101001010, 22, 2), 0);
        chk("t1_done",  done_pos(22), 21);
        chk("t1_len",   last_len, 22);
        chk("t1_after", tx_serial, 1'b1);

        // 2: P=8, 5-bit MSB, no parity, 2 stop, upper data bits set
        drive(mk(2, 4, 5, 2, 1, 0, 0));
        send(8'hF3);
        capture(64);
        chk("t2_bits", {cap[4], cap[12], cap[20], cap[28], cap[36], cap[44]}, 6'b010011);
        ones = 0;
        for (int k = 48; k < 64; k++) if (cap[k] === 1'b1) ones++;
        chk("t2_stop_high", ones, 16);
        chk("t2_done", done_pos(64), 63);
        chk("t2_len",  last_len, 64);

        // 3: P=2, 7-bit, odd parity, 1.5 stop, 0x7F
        drive(mk(1, 2, 7, 0, 0, 1, 1));
        send(8'h7F);
        capture(21);
        chk("t3_line",   line_bad(32'b1011111110, 20, 2), 0);
        chk("t3_parity", {cap[16], cap[17]}, 2'b00);
        chk("t3_stop3",  cap[20], 1'b1);
        chk("t3_done",   done_pos(21), 20);
        chk("t3_len",    last_len, 21);

        // 4: invalid configs are rejected
        drive(mk(1, 2, 0, 1, 0, 0, 0));
        send(8'h11);
        chk("t4a_err", cfg_err, 1'b1);
        chk("t4a_serial", tx_serial, 1'b1);
        chk("t4a_busy", busy, 1'b0);
        chk("t4a_ready", tx_ready, 1'b1);
        @(negedge clk);
        chk("t4a_err_pulse", cfg_err, 1'b0);
        drive(mk(0, 2, 8, 1, 0, 0, 0));
        send(8'h22);
        chk("t4b_err", cfg_err, 1'b1);
        chk("t4b_busy", busy, 1'b0);
        @(negedge clk);

        // 5: reset during data bit 3, then a clean frame
        drive(mk(1, 2, 8, 1, 0, 0, 0));
        send(8'h3C);
        repeat (8) @(negedge clk);
        chk("t5_in_data", fsm_state, DATA_STATE);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_serial", tx_serial, 1'b1);
        chk("t5_state",  fsm_state, IDLE_STATE);
        chk("t5_ready",  tx_ready,  1'b1);
        send(8'h96);
        capture(20);
        chk("t5_line", line_bad(32'b1100101100, 20, 2), 0);
        chk("t5_done", done_pos(20), 19);

        // 6: valid held for three characters, cfg scrambled mid-frame
        base = mk(1, 2, 8, 1, 0, 1, 0);
        chars[0] = 8'h55; chars[1] = 8'hC3; chars[2] = 8'h0F;
        tx_valid = 1'b1; nsent = 0; ndone = 0; gap = 0; counting = 1'b0;
        for (int cyc = 0; cyc < 400 && ndone < 3; cyc++) begin
            @(negedge clk);
            if (frame_done) begin
                ndone++;
                if (ndone < 3) begin gap = 0; counting = 1'b1; end
            end else if (counting) begin
                if (!busy) gap++;
                else begin chk("t6_gap", gap, 1); counting = 1'b0; end
            end
            if (tx_ready) begin
                if (nsent == 3) tx_valid = 1'b0;
                else begin drive(base); tx_data = chars[nsent]; nsent++; end
            end else begin
                drive(rand_cfg(1'b1));
            end
        end
        tx_valid = 1'b0;
        chk("t6_frames", ndone, 3);
        @(negedge clk);

        // random traffic: valid gaps, bad configs, cfg churn, occasional reset
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 799) == 0);
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = 8'($urandom);
            drive(rand_cfg(1'b1));
        end
        tx_valid = 1'b0; reset = 1'b0;
        w = 0;
        @(negedge clk);
        while (busy && w < 1000) begin @(negedge clk); w++; end
        chk("drain_idle", busy, 1'b0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
